cordic_vectoring_iter: RTL and testbench

- Iterative CORDIC in vectoring mode. This is the inverse of the rotation-mode datapath: the rotation path drives z to zero, while this block drives y to zero.
- Accepts a Cartesian vector (x, y) and returns its angle (atan2) and its gain-uncorrected magnitude.
- Performs one micro-rotation per clock, with a valid/ready handshake on both sides.
- Converts back the (x, y) results produced by the rotation units before they reach the angle-tracking logic downstream.

---
 rtl/cordic_pkg.sv | 47 ++++
 rtl/cordic_vec_stage.sv | 34 +++
 rtl/cordic_vectoring_iter.sv | 136 +++++++++++++
 tb/tb_cordic_vectoring_iter.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cordic_pkg.sv
// Shared CORDIC constants: arctangent table, quadrant angles, gain and FSM states.
package cordic_pkg;

   localparam int unsigned ATAN_ENTRIES = 32;
   localparam int unsigned ATAN_MAX_W   = 32;

   // atan(2^-i) scaled so that 2^31 = 180 degrees, rounded to nearest
   localparam logic [31:0] ATAN32 [ATAN_ENTRIES] = '{
      32'h20000000, 32'h12E4051E, 32'h09FB385B, 32'h051111D4,
      32'h028B0D43, 32'h0145D7E1, 32'h00A2F61E, 32'h00517C55,
      32'h0028BE53, 32'h00145F2F, 32'h000A2F98, 32'h000517CC,
      32'h00028BE6, 32'h000145F3, 32'h0000A2FA, 32'h0000517D,
      32'h000028BE, 32'h0000145F, 32'h00000A30, 32'h00000518,
      32'h0000028C, 32'h00000146, 32'h000000A3, 32'h00000051,
      32'h00000029, 32'h00000014, 32'h0000000A, 32'h00000005,
      32'h00000003, 32'h00000001, 32'h00000001, 32'h00000000
   };

   // Accumulated CORDIC gain K in Q1.23, for downstream magnitude correction
   localparam logic [23:0] CORDIC_GAIN_Q = 24'd13814026;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ROTATE,
      ST_DONE
   } cordic_state_e;

   // Arctangent entry rescaled to a w-bit angle where 2^(w-1) = 180 degrees
   function automatic logic [31:0] atan_entry(input int unsigned idx, input int unsigned w);
      logic [31:0]  v;
      int unsigned  sh;
      if (idx >= ATAN_ENTRIES) return 32'd0;
      v  = ATAN32[idx];
      sh = ATAN_MAX_W - w;
      if (sh == 0) return v;
      return (v + (32'd1 << (sh - 1))) >> sh;
   endfunction

   function automatic logic [31:0] ang_90(input int unsigned w);
      return 32'd1 << (w - 2);
   endfunction

   function automatic logic [31:0] ang_180(input int unsigned w);
      return 32'd1 << (w - 1);
   endfunction

endpackage

// File: rtl/cordic_vec_stage.sv
// One combinational vectoring-mode micro-rotation: steers y toward zero.
module cordic_vec_stage
   import cordic_pkg::*;
#(
   parameter int unsigned WIDTH = 24,
   parameter int unsigned CW    = 4
)
(
   input  logic signed [WIDTH+1:0] i_x,
   input  logic signed [WIDTH+1:0] i_y,
   input  logic signed [WIDTH-1:0] i_z,
   input  logic        [CW-1:0]    i_i,
   output logic signed [WIDTH+1:0] o_x_c,
   output logic signed [WIDTH+1:0] o_y_c,
   output logic signed [WIDTH-1:0] o_z_c
);

   localparam int unsigned XW = WIDTH + 2;

   logic signed [XW-1:0]    w_xs;
   logic signed [XW-1:0]    w_ys;
   logic signed [WIDTH-1:0] w_atan;
   logic                    w_y_neg;

   assign w_xs    = i_x >>> i_i;
   assign w_ys    = i_y >>> i_i;
   assign w_atan  = WIDTH'(atan_entry(32'(i_i), WIDTH));
   assign w_y_neg = i_y[XW-1];

   assign o_x_c = w_y_neg ? (i_x - w_ys)   : (i_x + w_ys);
   assign o_y_c = w_y_neg ? (i_y + w_xs)   : (i_y - w_xs);
   assign o_z_c = w_y_neg ? (i_z - w_atan) : (i_z + w_atan);

endmodule

// File: rtl/cordic_vectoring_iter.sv
// Iterative vectoring CORDIC: returns atan2(y, x) and K-scaled magnitude, one micro-rotation per clock.
module cordic_vectoring_iter
   import cordic_pkg::*;
#(
   parameter int unsigned WIDTH = 24,
   parameter int unsigned ITER  = 16
)
(
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic signed [WIDTH-1:0] x_i,
   input  logic signed [WIDTH-1:0] y_i,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic        [WIDTH:0]   mag_o,
   output logic signed [WIDTH-1:0] angle_o
);

   localparam int unsigned XW = WIDTH + 2;
   localparam int unsigned CW = (ITER > 1) ? $clog2(ITER) : 1;
   localparam logic signed [WIDTH-1:0] ANG90 = WIDTH'(ang_90(WIDTH));

   cordic_state_e           r_state;
   logic [CW-1:0]           r_cnt;
   logic signed [XW-1:0]    r_x;
   logic signed [XW-1:0]    r_y;
   logic signed [WIDTH-1:0] r_z;
   logic                    r_zero;
   logic                    r_in_ready;
   logic                    r_out_valid;
   logic [WIDTH:0]          r_mag;
   logic signed [WIDTH-1:0] r_angle;

   logic signed [XW-1:0]    w_xe;
   logic signed [XW-1:0]    w_ye;
   logic signed [XW-1:0]    w_x0;
   logic signed [XW-1:0]    w_y0;
   logic signed [WIDTH-1:0] w_z0;
   logic signed [XW-1:0]    w_xn;
   logic signed [XW-1:0]    w_yn;
   logic signed [WIDTH-1:0] w_zn;

   assign w_xe = XW'(x_i);
   assign w_ye = XW'(y_i);

   // Quadrant pre-rotation by +/-90 degrees brings the vector into the right half-plane
   always_comb begin
      w_x0 = w_xe;
      w_y0 = w_ye;
      w_z0 = '0;
      if (x_i[WIDTH-1]) begin
         if (!y_i[WIDTH-1]) begin
            w_x0 = w_ye;
            w_y0 = -w_xe;
            w_z0 = ANG90;
         end else begin
            w_x0 = -w_ye;
            w_y0 = w_xe;
            w_z0 = -ANG90;
         end
      end
   end

   cordic_vec_stage #(
      .WIDTH (WIDTH),
      .CW    (CW)
   ) u_stage (
      .i_x   (r_x),
      .i_y   (r_y),
      .i_z   (r_z),
      .i_i   (r_cnt),
      .o_x_c (w_xn),
      .o_y_c (w_yn),
      .o_z_c (w_zn)
   );

   // Control FSM, iteration counter and registered result
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= ST_IDLE;
         r_cnt       <= '0;
         r_x         <= '0;
         r_y         <= '0;
         r_z         <= '0;
         r_zero      <= 1'b0;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
         r_mag       <= '0;
         r_angle     <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (in_valid) begin
                  r_x        <= w_x0;
                  r_y        <= w_y0;
                  r_z        <= w_z0;
                  r_cnt      <= '0;
                  r_zero     <= (x_i == '0) && (y_i == '0);
                  r_in_ready <= 1'b0;
                  r_state    <= ST_ROTATE;
               end
            end
            ST_ROTATE: begin
               r_x <= w_xn;
               r_y <= w_yn;
               r_z <= w_zn;
               if (r_cnt == CW'(ITER - 1)) begin
                  r_state     <= ST_DONE;
                  r_out_valid <= 1'b1;
                  r_mag       <= (WIDTH+1)'(w_xn);
                  // A zero vector has no direction; report angle 0 instead of the summed table
                  r_angle     <= r_zero ? '0 : w_zn;
               end else begin
                  r_cnt <= r_cnt + CW'(1);
               end
            end
            ST_DONE: begin
               if (out_ready) begin
                  r_out_valid <= 1'b0;
                  r_in_ready  <= 1'b1;
                  r_state     <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign mag_o     = r_mag;
   assign angle_o   = r_angle;

endmodule

// File: tb/tb_cordic_vectoring_iter.sv
// Self-checking bench for cordic_vectoring_iter: directed table, backpressure, reset abort, streaming.
module tb_cordic_vectoring_iter;

   localparam int unsigned W    = 24;
   localparam int unsigned ITER = 16;
   localparam longint TOL_ANG   = 128;
   localparam longint TOL_MAG   = 64;
   localparam real    KGAIN     = 1.6467602581210656;
   localparam real    PI        = 3.141592653589793;
   localparam int     NSTREAM   = 100;
   localparam int     NVEC      = 10;

   typedef struct {
      int     x;
      int     y;
      longint mag;
      longint ang;
   } vec_t;

   logic                clk = 1'b0;
   logic                reset;
   logic                in_valid;
   logic                in_ready;
   logic signed [W-1:0] x_i;
   logic signed [W-1:0] y_i;
   logic                out_valid;
   logic                out_ready;
   logic [W:0]          mag_o;
   logic signed [W-1:0] angle_o;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   cordic_vectoring_iter #(
      .WIDTH (W),
      .ITER  (ITER)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .x_i       (x_i),
      .y_i       (y_i),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .mag_o     (mag_o),
      .angle_o   (angle_o)
   );

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_eq(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Angles compare modulo 2^W so that results on either side of +/-180 match
   task automatic check_tol(input string name, input longint act, input longint exp,
                            input longint tol, input bit wrap);
      longint              d;
      logic signed [W-1:0] d24;
      checks++;
      if (wrap) begin
         d24 = W'(act - exp);
         d   = longint'(d24);
      end else begin
         d = act - exp;
      end
      if (d < 0) d = -d;
      if (d > tol) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (+/-%0d)", name, act, exp, tol);
      end
   endtask

   task automatic run_vec(input int x, input int y, output longint mag, output longint ang,
                          output int lat);
      int n;
      x_i      = W'(x);
      y_i      = W'(y);
      in_valid = 1'b1;
      n = 0;
      while (!in_ready && n < 50) begin
         tick();
         n++;
      end
      tick();
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 100) begin
         tick();
         lat++;
      end
      mag = longint'(mag_o);
      ang = longint'(angle_o);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   vec_t   tbl [NVEC];
   int     sx  [NSTREAM];
   int     sy  [NSTREAM];

   initial begin
      longint mag, ang, cap_mag, cap_ang;
      int     lat, n, bad;
      int     sent, got, cyc, last_cyc;
      bit     acc;
      real    exp_mag, exp_ang;

      tbl[0] = '{ 1000000,        0,  1646760,        0};
      tbl[1] = '{ 1000000,  1000000,  2328871,  2097152};
      tbl[2] = '{       0, -1000000,  1646760, -4194304};
      tbl[3] = '{-1000000,       -1,  1646760, -8388608};
      tbl[4] = '{       0,  1000000,  1646760,  4194304};
      tbl[5] = '{-1000000,  1000000,  2328871,  6291456};
      tbl[6] = '{ 1000000, -1000000,  2328871, -2097152};
      tbl[7] = '{       0,        0,        0,        0};
      tbl[8] = '{-8388608,        0, 13814026, -8388608};
      tbl[9] = '{ 8388607, -8388608, 19535982, -2097152};

      reset     = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      x_i       = '0;
      y_i       = '0;
      repeat (2) tick();
      check_eq("rst_out_valid", longint'(out_valid), 0);
      check_eq("rst_in_ready",  longint'(in_ready), 1);
      check_eq("rst_mag",       longint'(mag_o), 0);
      check_eq("rst_angle",     longint'(angle_o), 0);
      reset = 1'b0;
      tick();

      for (int k = 0; k < NVEC; k++) begin
         run_vec(tbl[k].x, tbl[k].y, mag, ang, lat);
         check_eq($sformatf("lat_v%0d", k), longint'(lat), longint'(ITER));
         check_tol($sformatf("mag_v%0d", k), mag, tbl[k].mag, TOL_MAG, 1'b0);
         check_tol($sformatf("ang_v%0d", k), ang, tbl[k].ang, TOL_ANG, 1'b1);
         check_eq($sformatf("in_ready_v%0d", k), longint'(in_ready), 1);
      end

      // Backpressure: result must hold and new requests must be ignored
      x_i = W'(1000000);
      y_i = W'(1000000);
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      n = 0;
      while (!out_valid && n < 100) begin
         tick();
         n++;
      end
      check_eq("bp_lat", longint'(n), longint'(ITER));
      cap_mag = longint'(mag_o);
      cap_ang = longint'(angle_o);
      check_tol("bp_mag_val", cap_mag, 2328871, TOL_MAG, 1'b0);
      check_tol("bp_ang_val", cap_ang, 2097152, TOL_ANG, 1'b1);
      for (int c = 0; c < 5; c++) begin
         in_valid = (c % 2 == 0);
         x_i = W'(-5);
         y_i = W'(7);
         tick();
         check_eq($sformatf("bp_valid_%0d", c), longint'(out_valid), 1);
         check_eq($sformatf("bp_in_ready_%0d", c), longint'(in_ready), 0);
         check_eq($sformatf("bp_mag_hold_%0d", c), longint'(mag_o), cap_mag);
         check_eq($sformatf("bp_ang_hold_%0d", c), longint'(angle_o), cap_ang);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check_eq("bp_release_valid", longint'(out_valid), 0);
      check_eq("bp_release_ready", longint'(in_ready), 1);
      bad = 0;
      for (int c = 0; c < int'(ITER) + 4; c++) begin
         tick();
         if (out_valid) bad++;
      end
      check_eq("bp_no_ghost", longint'(bad), 0);

      // Reset in the middle of ROTATE discards the transaction
      x_i = W'(1000000);
      y_i = W'(0);
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      repeat (6) tick();
      reset = 1'b1;
      tick();
      check_eq("mid_rst_valid", longint'(out_valid), 0);
      check_eq("mid_rst_mag",   longint'(mag_o), 0);
      check_eq("mid_rst_angle", longint'(angle_o), 0);
      check_eq("mid_rst_ready", longint'(in_ready), 1);
      reset = 1'b0;
      bad = 0;
      for (int c = 0; c < int'(ITER) + 4; c++) begin
         tick();
         if (out_valid) bad++;
      end
      check_eq("mid_rst_no_stale", longint'(bad), 0);

      // Continuous streaming against a floating-point atan2/hypot reference
      for (int k = 0; k < NSTREAM; k++) begin
         do begin
            sx[k] = int'($urandom_range(16777214)) - 8388607;
            sy[k] = int'($urandom_range(16777214)) - 8388607;
         end while ((longint'(sx[k]) * sx[k] + longint'(sy[k]) * sy[k]) < (longint'(1) << 42));
      end
      sent = 0;
      got = 0;
      cyc = 0;
      last_cyc = 0;
      x_i = W'(sx[0]);
      y_i = W'(sy[0]);
      in_valid  = 1'b1;
      out_ready = 1'b1;
      while (got < NSTREAM && cyc < 5000) begin
         acc = in_valid && in_ready;
         if (out_valid) begin
            exp_mag = KGAIN * $sqrt(real'(sx[got]) * real'(sx[got]) + real'(sy[got]) * real'(sy[got]));
            exp_ang = $atan2(real'(sy[got]), real'(sx[got])) * 8388608.0 / PI;
            check_tol($sformatf("stream_mag_%0d", got), longint'(mag_o), longint'(exp_mag),
                      TOL_MAG, 1'b0);
            check_tol($sformatf("stream_ang_%0d", got), longint'(angle_o), longint'(exp_ang),
                      TOL_ANG, 1'b1);
            if (got > 0)
               check_eq($sformatf("stream_gap_%0d", got), longint'(cyc - last_cyc),
                        longint'(ITER + 2));
            last_cyc = cyc;
            got++;
         end
         tick();
         cyc++;
         if (acc) begin
            sent++;
            if (sent < NSTREAM) begin
               x_i = W'(sx[sent]);
               y_i = W'(sy[sent]);
            end else begin
               in_valid = 1'b0;
            end
         end
      end
      check_eq("stream_count", longint'(got), longint'(NSTREAM));
      in_valid  = 1'b0;
      out_ready = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
